// File: rtl/codes_pkg.sv
// Shared types and the 4-to-16 one-hot decode function for the code stream blocks.
package codes_pkg;

    typedef logic [3:0]  code4_t;
    typedef logic [15:0] onehot16_t;

    // One-hot decode of a 4-bit binary code: bit <code> set, all others clear.
    function automatic onehot16_t dec_4to16(input code4_t code);
        onehot16_t word;
        word = 16'h0001 << code;
        return word;
    endfunction

endpackage

// File: rtl/seq_codes_dec_4to16_fifo.sv
// Small val/rdy FIFO of 4-bit codes with an occupancy count.
// A full FIFO refuses input even if the head leaves in the same cycle,
// so enq_rdy depends on the registered count only.
module seq_codes_dec_4to16_fifo
    import codes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enq_val,
    output logic                         enq_rdy,
    input  code4_t                       enq_data,
    output logic                         deq_val,
    input  logic                         deq_rdy,
    output code4_t                       deq_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    code4_t             mem_q [DEPTH];
    code4_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               enq_s;
    logic               deq_s;

    assign enq_rdy  = (count_q < CNT_W'(DEPTH));
    assign deq_val  = (count_q != {CNT_W{1'b0}});
    assign deq_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state: store at tail on enqueue, advance head on dequeue, track occupancy.
    always_comb begin
        enq_s    = enq_val & enq_rdy;
        deq_s    = deq_val & deq_rdy;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (enq_s) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered code immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: 4'h0};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/seq_codes_dec_4to16.sv
// Flow-controlled 4-to-16 decoder: buffers binary codes, presents the head as a
// one-hot word, and keeps a sticky mask of every word delivered since the last clear.
module seq_codes_dec_4to16
    import codes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic [3:0]                   in_,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [15:0]                  out,
    input  logic                         clear,
    output logic [15:0]                  seen,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    code4_t     head_code_s;
    onehot16_t  out_s;
    logic       deq_s;
    onehot16_t  seen_q;
    onehot16_t  seen_d;

    seq_codes_dec_4to16_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .enq_val  (in_val),
        .enq_rdy  (in_rdy),
        .enq_data (in_),
        .deq_val  (out_val),
        .deq_rdy  (out_rdy),
        .deq_data (head_code_s),
        .count    (count)
    );

    // Decode the head entry; the output word is forced to zero while the FIFO is empty.
    always_comb begin
        out_s = 16'h0000;
        deq_s = out_val & out_rdy;
        if (out_val) begin
            out_s = dec_4to16(head_code_s);
        end else begin
            out_s = 16'h0000;
        end
    end

    // Sticky mask: clear wipes history, but a word delivered in the clearing cycle still lands.
    always_comb begin
        seen_d = seen_q;
        if (clear) begin
            seen_d = 16'h0000;
        end else begin
            seen_d = seen_q;
        end
        if (deq_s) begin
            seen_d = seen_d | out_s;
        end else begin
            seen_d = seen_d;
        end
    end

    // Seen-mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q <= 16'h0000;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign out  = out_s;
    assign seen = seen_q;

endmodule

// File: tb/tb_seq_codes_dec_4to16.sv
// Directed self-checking bench for seq_codes_dec_4to16 (DEPTH = 2).
module tb_seq_codes_dec_4to16;

    logic        clk;
    logic        reset_n;
    logic        in_val;
    logic        in_rdy;
    logic [3:0]  in_;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out;
    logic        clear;
    logic [15:0] seen;
    logic [1:0]  count;

    int n_cmp;
    int n_bad;

    seq_codes_dec_4to16 #(.DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out     (out),
        .clear   (clear),
        .seen    (seen),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_val = 1'b0; in_ = 4'h0; out_rdy = 1'b0; clear = 1'b0;
        #23;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL reset_out_val: got %b expected 0", out_val); end
        n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h expected 0000", out); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_in_rdy: got %b expected 1", in_rdy); end
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (seen !== 16'h0000) begin n_bad++; $display("FAIL reset_seen: got %h expected 0000", seen); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_w;
        out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_val = 1'b1;
            in_    = 4'(i);
            step();
            exp_w = 16'h0001;
            exp_w = exp_w << i;
            n_cmp++; if (out !== exp_w || out_val !== 1'b1) begin n_bad++; $display("FAIL stream_out[%0d]: got %h val %b expected %h val 1", i, out, out_val, exp_w); end
            n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
            n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL stream_in_rdy[%0d]: got %b expected 1", i, in_rdy); end
        end
        in_val = 1'b0;
        step();
        n_cmp++; if (out_val !== 1'b0 || out !== 16'h0000) begin n_bad++; $display("FAIL stream_drain: got val %b out %h expected 0 0000", out_val, out); end
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL stream_count_end: got %0d expected 0", count); end
        n_cmp++; if (seen !== 16'hFFFF) begin n_bad++; $display("FAIL stream_seen: got %h expected FFFF", seen); end
    endtask

    task automatic test_backpressure();
        clear = 1'b1; out_rdy = 1'b0;
        step();
        clear = 1'b0;
        n_cmp++; if (seen !== 16'h0000) begin n_bad++; $display("FAIL bp_clear: got %h expected 0000", seen); end
        in_val = 1'b1; in_ = 4'd3;
        step();
        n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL bp_count1: got %0d expected 1", count); end
        in_ = 4'd7;
        step();
        n_cmp++; if (count !== 2'd2 || in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_full: got count %0d in_rdy %b expected 2 0", count, in_rdy); end
        in_ = 4'd9;
        step();
        n_cmp++; if (count !== 2'd2 || out !== 16'h0008) begin n_bad++; $display("FAIL bp_stall: got count %0d out %h expected 2 0008", count, out); end
        out_rdy = 1'b1;
        step();
        n_cmp++; if (count !== 2'd1 || out !== 16'h0080 || in_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_drain1: got count %0d out %h in_rdy %b expected 1 0080 1", count, out, in_rdy); end
        step();
        n_cmp++; if (count !== 2'd1 || out !== 16'h0200) begin n_bad++; $display("FAIL bp_drain2: got count %0d out %h expected 1 0200", count, out); end
        in_val = 1'b0;
        step();
        n_cmp++; if (count !== 2'd0 || seen !== 16'h0288) begin n_bad++; $display("FAIL bp_end: got count %0d seen %h expected 0 0288", count, seen); end
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b0; clear = 1'b1; in_val = 1'b1; in_ = 4'd2;
        step();
        clear = 1'b0;
        n_cmp++; if (count !== 2'd1 || out !== 16'h0004 || seen !== 16'h0000) begin n_bad++; $display("FAIL b2b_setup: got count %0d out %h seen %h expected 1 0004 0000", count, out, seen); end
        in_ = 4'd5; out_rdy = 1'b1;
        step();
        n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL b2b_count: got %0d expected 1", count); end
        n_cmp++; if (out !== 16'h0020) begin n_bad++; $display("FAIL b2b_out: got %h expected 0020", out); end
        n_cmp++; if (seen !== 16'h0004) begin n_bad++; $display("FAIL b2b_seen: got %h expected 0004", seen); end
        in_val = 1'b0;
        step();
        n_cmp++; if (count !== 2'd0 || seen !== 16'h0024) begin n_bad++; $display("FAIL b2b_end: got count %0d seen %h expected 0 0024", count, seen); end
    endtask

    task automatic test_clear();
        out_rdy = 1'b1; in_val = 1'b1; in_ = 4'd4;
        step();
        in_ = 4'd6;
        step();
        n_cmp++; if (seen !== 16'h0034 || out !== 16'h0040) begin n_bad++; $display("FAIL clr_pre: got seen %h out %h expected 0034 0040", seen, out); end
        in_val = 1'b0; clear = 1'b1;
        step();
        n_cmp++; if (seen !== 16'h0040) begin n_bad++; $display("FAIL clr_with_deq: got %h expected 0040", seen); end
        step();
        n_cmp++; if (seen !== 16'h0000) begin n_bad++; $display("FAIL clr_only: got %h expected 0000", seen); end
        clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1; in_val = 1'b1; in_ = 4'd8;
        step();
        in_val = 1'b0;
        step();
        n_cmp++; if (seen !== 16'h0100) begin n_bad++; $display("FAIL rm_seen_pre: got %h expected 0100", seen); end
        out_rdy = 1'b0; in_val = 1'b1; in_ = 4'd1;
        step();
        in_ = 4'd2;
        step();
        in_val = 1'b0;
        n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL rm_count_pre: got %0d expected 2", count); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (out_val !== 1'b0 || out !== 16'h0000) begin n_bad++; $display("FAIL rm_async_out: got val %b out %h expected 0 0000", out_val, out); end
        n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL rm_async_count: got %0d expected 0", count); end
        n_cmp++; if (seen !== 16'h0000) begin n_bad++; $display("FAIL rm_async_seen: got %h expected 0000", seen); end
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_val !== 1'b0 || count !== 2'd0) begin n_bad++; $display("FAIL rm_stale[%0d]: got val %b count %0d expected 0 0", i, out_val, count); end
        end
        in_val = 1'b1; in_ = 4'hA;
        step();
        in_val = 1'b0;
        n_cmp++; if (out !== 16'h0400 || out_val !== 1'b1) begin n_bad++; $display("FAIL rm_after: got out %h val %b expected 0400 1", out, out_val); end
        step();
        n_cmp++; if (seen !== 16'h0400) begin n_bad++; $display("FAIL rm_seen_after: got %h expected 0400", seen); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
